// File: rtl/op_spike_dec.sv
// Output-layer spike decoder: counts spikes per neuron over a W-step window,
// then scans the counts one neuron per cycle to pick the winning class.

module op_spike_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt
);
    logic [CW-1:0] cnt_q, cnt_d;

    // Saturating counter: holds at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != {CW{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

module op_spike_dec #(
    parameter int N   = 10,
    parameter int W   = 24,
    parameter int CW  = 8,
    parameter int CLW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_dec,
    input  logic [N-1:0]    spike_in,
    input  logic            spike_valid,
    output logic [CW*N-1:0] count,
    output logic [CLW-1:0]  class_out,
    output logic [CW-1:0]   max_count,
    output logic            valid_dec,
    output logic            busy
);
    localparam int STW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [STW-1:0]           step_q, step_d;
    logic [CLW-1:0]           idx_q, idx_d;
    logic [CLW-1:0]           class_q, class_d;
    logic [CW-1:0]            max_q, max_d;
    logic                     clr, inc_en;
    logic [N-1:0][CW-1:0]     cnt;
    logic [CW-1:0]            cur_cnt;

    for (genvar i = 0; i < N; i++) begin : g_lane
        op_spike_cnt #(.CW(CW)) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .inc (inc_en & spike_in[i]),
            .cnt (cnt[i])
        );
    end

    // Mux out the count under examination; indices >= N never occur in SCAN.
    always_comb begin
        cur_cnt = '0;
        for (int i = 0; i < N; i++)
            if (idx_q == CLW'(i)) cur_cnt = cnt[i];
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        idx_d   = idx_q;
        class_d = class_q;
        max_d   = max_q;
        clr     = 1'b0;
        inc_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_dec) begin
                    clr     = 1'b1;
                    step_d  = '0;
                    class_d = '0;
                    max_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (spike_valid) begin
                    inc_en = 1'b1;
                    step_d = step_q + 1'b1;
                    if (step_q == STW'(W - 1)) begin
                        idx_d   = '0;
                        class_d = '0;
                        max_d   = '0;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if (cur_cnt > max_q) begin
                    class_d = idx_q;
                    max_d   = cur_cnt;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == CLW'(N - 1))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            idx_q   <= '0;
            class_q <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            class_q <= class_d;
            max_q   <= max_d;
        end
    end

    assign count     = cnt;
    assign class_out = class_q;
    assign max_count = max_q;
    assign valid_dec = (state_q == DONE);
    assign busy      = (state_q != IDLE);
endmodule

// File: doc/op_spike_dec.md
OP_SPIKE_DEC -- requirements
Module: op_spike_dec

Interface
REQ-001 SHALL have parameter N, default 10, number of output-layer neurons decoded.
REQ-002 SHALL have parameter W, default 24, number of timesteps per image window.
REQ-003 SHALL have parameter CW, default 8, per-neuron spike count width.
REQ-004 SHALL have parameter CLW, default 4, class index width, with 2^CLW >= N.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 start_dec  input  1  single-cycle pulse that begins one decode window.
REQ-009 spike_in  input  N  spike bit per output neuron for the current timestep.
REQ-010 spike_valid  input  1  qualifies spike_in as one timestep.
REQ-011 count  output  CW*N  packed spike counts; neuron i occupies bits [CW*i+CW-1 : CW*i].
REQ-012 class_out  output  CLW  index of the winning neuron.
REQ-013 max_count  output  CW  spike count of the winning neuron.
REQ-014 valid_dec  output  1  single-cycle pulse indicating class_out and max_count are final.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement the states IDLE, ACCUM, SCAN and DONE.
REQ-017 IDLE: start_dec=1 SHALL clear all counts, the step counter, class_out and max_count, then enter ACCUM on the next edge.
REQ-018 start_dec SHALL be ignored in ACCUM, SCAN and DONE.
REQ-019 ACCUM: on each edge with spike_valid=1, count[i] SHALL increment by spike_in[i], and the step counter SHALL increment.
REQ-020 ACCUM: cycles with spike_valid=0 SHALL leave counts and the step counter unchanged.
REQ-021 Counts SHALL saturate at 2^CW-1 and never wrap.
REQ-022 The edge that accepts the W-th valid timestep SHALL move the FSM to SCAN.
REQ-023 spike_valid and spike_in SHALL be ignored outside ACCUM.
REQ-024 SCAN: SHALL examine one neuron per cycle in order 0..N-1, taking exactly N cycles.
REQ-025 SCAN comparison SHALL be strictly greater-than, so ties resolve to the lowest index.
REQ-026 SCAN initial best SHALL be index 0 with count 0.
REQ-027 If all counts are zero, class_out SHALL be 0 and max_count SHALL be 0.
REQ-028 After the Nth comparison the FSM SHALL enter DONE.
REQ-029 DONE: valid_dec SHALL be high for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-030 valid_dec SHALL assert N+1 cycles after the edge that accepted the W-th timestep.
REQ-031 count, class_out and max_count SHALL hold their values in IDLE until the next accepted start_dec.
REQ-032 class_out and max_count SHALL be registered and SHALL not be treated as final before valid_dec.
REQ-033 start_dec arriving in the same cycle valid_dec is high SHALL be ignored.
REQ-034 start_dec arriving on the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-035 rst=1 SHALL, at the next edge, force IDLE and set all counts, the step counter, class_out, max_count, valid_dec and busy to 0.
REQ-036 rst SHALL take priority over start_dec, spike_valid and any FSM transition.
REQ-037 Reset asserted mid-ACCUM or mid-SCAN SHALL abort the window, and no valid_dec SHALL be produced for that window.

Verification
REQ-038 Defaults; neuron 3 spikes on all 24 valid steps, others silent -> count3=24, class_out=3, max_count=24, one valid_dec 11 cycles after the last step.
REQ-039 Neurons 2 and 7 each spike on 12 steps, others silent -> class_out=2, max_count=12.
REQ-040 No spikes for 24 steps -> all counts 0, class_out=0, max_count=0, valid_dec still pulses once.
REQ-041 24 valid steps interleaved with spike_valid=0 gaps, plus a start_dec pulse mid-ACCUM -> counts reflect only the 24 valid steps, and the extra start_dec has no effect.
REQ-042 CW=4, neuron 0 spikes on all 24 steps -> count0=15 (saturated), class_out=0, max_count=15.
REQ-043 rst at step 10 of ACCUM -> the following cycle busy=0 and counts=0, and no valid_dec is produced; a new start_dec then decodes correctly.
